// File: rtl/io_write_arbiter.sv
// Round-robin arbiter giving two write masters turns on the memory-mapped I/O bus.
// Each grant issues one registered bus write, acks the winner, then holds off for MIN_GAP idle cycles.
module io_write_arbiter #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] IO_BASE = 8'hF0,
  parameter int                MIN_GAP = 1,
  parameter int                GAP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              bus_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              err,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, GAP} state_e;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  state_e              state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                last_grant_q, last_grant_d;
  logic                err_flag_q, err_flag_d;
  logic                bus_en_q, bus_en_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;

  // On a tie the requester that was not served last wins.
  logic              win1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  assign win1     = req1 & (~req0 | ~last_grant_q);
  assign win_addr = win1 ? addr1 : addr0;
  assign win_data = win1 ? data1 : data0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req0 || req1) state_d = ISSUE;
      ISSUE: state_d = ACK;
      ACK:   state_d = (MIN_GAP > 0) ? GAP : IDLE;
      GAP:   if (gap_q <= GAP_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; everything lands in a register before leaving the block.
  always_comb begin
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    err_flag_d   = err_flag_q;
    bus_addr_d   = bus_addr_q;
    bus_data_d   = bus_data_q;
    grant_d      = grant_q;
    bus_en_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          bus_addr_d   = win_addr;
          bus_data_d   = win_data;
          grant_d      = win1;
          last_grant_d = win1;
          bus_en_d     = (win_addr >= IO_BASE);
          err_flag_d   = (win_addr < IO_BASE);
        end
      end
      ISSUE: begin
        ack0_d = ~grant_q;
        ack1_d = grant_q;
        err_d  = err_flag_q;
      end
      ACK: gap_d = GAP_LOAD;
      GAP: gap_d = gap_q - GAP_W'(1);
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q        <= '0;
      last_grant_q <= 1'b1;
      err_flag_q   <= 1'b0;
      bus_en_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
    end else begin
      gap_q        <= gap_d;
      last_grant_q <= last_grant_d;
      err_flag_q   <= err_flag_d;
      bus_en_q     <= bus_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
    end
  end

  assign bus_en   = bus_en_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign bus_addr = bus_addr_q;
  assign bus_data = bus_data_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench for io_write_arbiter: a per-cycle vector table on a MIN_GAP=1 instance,
// plus hand sequences for mid-transaction reset and back-to-back writes on a MIN_GAP=0 instance.
module tb_io_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, data0 = '0, addr1 = '0, data1 = '0;
  logic       ack0, ack1, bus_en, err, busy, grant_id;
  logic [7:0] bus_addr, bus_data;

  logic       z_req0 = 1'b0;
  logic       z_ack0, z_ack1, z_en, z_err, z_busy, z_gid;
  logic [7:0] z_addr, z_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_write_arbiter #(.MIN_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .bus_en(bus_en), .bus_addr(bus_addr), .bus_data(bus_data),
    .err(err), .busy(busy), .grant_id(grant_id)
  );

  io_write_arbiter #(.MIN_GAP(0)) dut0 (
    .clk(clk), .rst(rst),
    .req0(z_req0), .addr0(8'hFF), .data0(8'hC3), .ack0(z_ack0),
    .req1(1'b0), .addr1(8'h00), .data1(8'h00), .ack1(z_ack1),
    .bus_en(z_en), .bus_addr(z_addr), .bus_data(z_data),
    .err(z_err), .busy(z_busy), .grant_id(z_gid)
  );

  typedef struct {
    bit         do_rst;
    logic       r0;
    logic [7:0] a0, d0;
    logic       r1;
    logic [7:0] a1, d1;
    logic [21:0] exp;  // {bus_en, ack0, ack1, err, busy, grant_id, bus_addr, bus_data}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] outs();
    return {bus_en, ack0, ack1, err, busy, grant_id, bus_addr, bus_data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input bit rs, input logic r0, input logic [7:0] a0, input logic [7:0] d0,
                   input logic r1, input logic [7:0] a1, input logic [7:0] d1,
                   input logic en, input logic k0, input logic k1, input logic er,
                   input logic bz, input logic g, input logic [7:0] ba, input logic [7:0] bd);
    vec_t t;
    t.do_rst = rs; t.r0 = r0; t.a0 = a0; t.d0 = d0; t.r1 = r1; t.a1 = a1; t.d1 = d1;
    t.exp = {en, k0, k1, er, bz, g, ba, bd};
    vecs.push_back(t);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // Write to FF
    v(0, 1,8'hFF,8'hA5, 0,8'h00,8'h00, 1,0,0,0,1,0, 8'hFF,8'hA5);
    v(0, 1,8'hFF,8'hA5, 0,8'h00,8'h00, 0,1,0,0,1,0, 8'hFF,8'hA5);
    v(0, 0,8'hFF,8'hA5, 0,8'h00,8'h00, 0,0,0,0,1,0, 8'hFF,8'hA5);
    v(0, 0,8'hFF,8'hA5, 0,8'h00,8'h00, 0,0,0,0,0,0, 8'hFF,8'hA5);
    // Both held after reset: grants 0,1,0,1, bus_en four cycles apart
    v(1, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 1,0,0,0,1,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,1,0,0,1,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,0,0,1,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,0,0,0,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 1,0,0,0,1,1, 8'hFE,8'h22);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,1,0,1,1, 8'hFE,8'h22);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,0,0,1,1, 8'hFE,8'h22);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,0,0,0,1, 8'hFE,8'h22);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 1,0,0,0,1,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,1,0,0,1,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,0,0,1,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,0,0,0,0, 8'hFF,8'h11);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 1,0,0,0,1,1, 8'hFE,8'h22);
    v(0, 1,8'hFF,8'h11, 1,8'hFE,8'h22, 0,0,1,0,1,1, 8'hFE,8'h22);
    v(0, 0,8'hFF,8'h11, 0,8'hFE,8'h22, 0,0,0,0,1,1, 8'hFE,8'h22);
    v(0, 0,8'hFF,8'h11, 0,8'hFE,8'h22, 0,0,0,0,0,1, 8'hFE,8'h22);
    // Out-of-window address: no strobe, ack with err; next good write clean
    v(0, 0,8'h00,8'h00, 1,8'h10,8'h33, 0,0,0,0,1,1, 8'h10,8'h33);
    v(0, 0,8'h00,8'h00, 1,8'h10,8'h33, 0,0,1,1,1,1, 8'h10,8'h33);
    v(0, 0,8'h00,8'h00, 0,8'h10,8'h33, 0,0,0,0,1,1, 8'h10,8'h33);
    v(0, 0,8'h00,8'h00, 0,8'h10,8'h33, 0,0,0,0,0,1, 8'h10,8'h33);
    v(0, 1,8'hFF,8'h44, 0,8'h00,8'h00, 1,0,0,0,1,0, 8'hFF,8'h44);
    v(0, 1,8'hFF,8'h44, 0,8'h00,8'h00, 0,1,0,0,1,0, 8'hFF,8'h44);
    v(0, 0,8'hFF,8'h44, 0,8'h00,8'h00, 0,0,0,0,1,0, 8'hFF,8'h44);
    v(0, 0,8'hFF,8'h44, 0,8'h00,8'h00, 0,0,0,0,0,0, 8'hFF,8'h44);
    // req0 raised in GAP waits for IDLE; later addr/data edits are ignored
    v(0, 0,8'h00,8'h00, 1,8'hFE,8'h55, 1,0,0,0,1,1, 8'hFE,8'h55);
    v(0, 0,8'h00,8'h00, 1,8'hFE,8'h55, 0,0,1,0,1,1, 8'hFE,8'h55);
    v(0, 1,8'hFF,8'h66, 0,8'hFE,8'h55, 0,0,0,0,1,1, 8'hFE,8'h55);
    v(0, 1,8'hFF,8'h66, 0,8'hFE,8'h55, 0,0,0,0,0,1, 8'hFE,8'h55);
    v(0, 1,8'hFF,8'h66, 0,8'hFE,8'h55, 1,0,0,0,1,0, 8'hFF,8'h66);
    v(0, 1,8'hF0,8'h77, 0,8'hFE,8'h55, 0,1,0,0,1,0, 8'hFF,8'h66);
    v(0, 0,8'hF0,8'h77, 0,8'hFE,8'h55, 0,0,0,0,1,0, 8'hFF,8'h66);
    v(0, 0,8'hF0,8'h77, 0,8'hFE,8'h55, 0,0,0,0,0,0, 8'hFF,8'h66);

    apply_reset();
    check("reset_outputs", 32'(outs()), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) apply_reset();
      req0 = vecs[i].r0; addr0 = vecs[i].a0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; addr1 = vecs[i].a1; data1 = vecs[i].d1;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Reset during ISSUE clears everything at once; last_grant returns to 1
    req0 = 1'b1; addr0 = 8'hFF; data0 = 8'h88;
    req1 = 1'b0; addr1 = 8'hFE; data1 = 8'h99;
    @(posedge clk);
    #1 check("pre_reset_issue", 32'({bus_en, busy, grant_id}), 32'(3'b110));
    rst = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'd0);
    req1 = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("retry_issue", 32'(outs()), 32'({6'b100010, 8'hFF, 8'h88}));
    @(posedge clk);
    #1 check("retry_ack", 32'(outs()), 32'({6'b010010, 8'hFF, 8'h88}));
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);

    // Zero-gap build: bus_en every 3 cycles, busy low one cycle between
    #1 z_req0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 check($sformatf("gap0_cyc%0d", i), 32'({z_en, z_ack0, z_busy}),
               32'({(i % 3 == 0), (i % 3 == 1), (i % 3 != 2)}));
    end
    z_req0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
